// File: rtl/sensor_rx_pkg.sv
// Shared types and constants for the sensor LVDS frame receiver.
// Optional data checking is enabled by SENSOR_RX_DATA_CHECK_EN.
package sensor_rx_pkg;

    typedef enum logic [2:0] {
        HUNT0,
        HUNT1,
        EXP_ANY,
        EXP_IDLE1,
        FRAME
    } state_t;

    localparam int HEADER_WIDTH = 32;
    localparam int COUNT_WIDTH  = 16;
    localparam int MIN_CPF      = 4;

endpackage

// File: rtl/sensor_frame_rx_if.sv
// Push-only AXI-stream bundle carrying received frame beats.
// No TREADY: the sink must accept every beat.
interface sensor_frame_rx_if #(
    parameter int LVDS_WIDTH = 512
) ();
    logic [LVDS_WIDTH-1:0] M_TDATA;
    logic                  M_TVALID;
    logic                  M_TUSER;
    logic                  M_TLAST;

    modport master (
        output M_TDATA, M_TVALID, M_TUSER, M_TLAST
    );

    modport slave (
        input M_TDATA, M_TVALID, M_TUSER, M_TLAST
    );
endinterface

// File: rtl/sensor_rx_pattern_chk.sv
// Captures the replicated cell pattern on SOF and flags masked mismatches.
// Built only when SENSOR_RX_DATA_CHECK_EN is defined.
module sensor_rx_pattern_chk
    import sensor_rx_pkg::*;
#(
    parameter int LVDS_WIDTH    = 512,
    parameter int PATTERN_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [LVDS_WIDTH-1:0] i_lvds,
    input  logic                  i_sof,
    input  logic                  i_beat,
    input  logic                  i_last,
    output logic                  o_mismatch
);
    localparam int REPS = LVDS_WIDTH / PATTERN_WIDTH;

    logic [PATTERN_WIDTH-1:0] r_pat;
    logic [PATTERN_WIDTH-1:0] w_pat;
    logic [LVDS_WIDTH-1:0]    w_exp;
    logic [LVDS_WIDTH-1:0]    w_mask;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_pat <= '0;
        end else if (i_sof) begin
            r_pat <= i_lvds[PATTERN_WIDTH-1:0];
        end
    end

    // The SOF word is checked against its own freshly captured pattern
    assign w_pat = i_sof ? i_lvds[PATTERN_WIDTH-1:0] : r_pat;
    assign w_exp = {REPS{w_pat}};

    always_comb begin
        w_mask = '1;
        if (i_sof) w_mask[LVDS_WIDTH-1 -: HEADER_WIDTH] = '0;
        if (i_last) w_mask[HEADER_WIDTH-1:0] = '0;
    end

    assign o_mismatch = i_beat && (|((i_lvds ^ w_exp) & w_mask));
endmodule

// File: rtl/sensor_frame_rx.sv
// LVDS frame receiver: idle lock, header detect, cycle-count framing.
// Define SENSOR_RX_DATA_CHECK_EN to enable the per-beat pattern check.
module sensor_frame_rx
    import sensor_rx_pkg::*;
#(
    parameter int LVDS_WIDTH    = 512,
    parameter int PATTERN_WIDTH = 32,
    parameter int LOCK_PAIRS    = 4
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic [LVDS_WIDTH-1:0]   lvds,
    input  logic [7:0]              idle_0,
    input  logic [7:0]              idle_1,
    input  logic [HEADER_WIDTH-1:0] frame_header,
    input  logic [31:0]             cycles_per_frame,
    sensor_frame_rx_if.master       m_axis,
    output logic                    locked,
    output logic                    sync_err,
    output logic                    eof_err,
    output logic                    data_err,
    output logic [COUNT_WIDTH-1:0]  sync_err_count,
    output logic [COUNT_WIDTH-1:0]  data_err_count,
    output logic [31:0]             frame_count
);
    if ((LVDS_WIDTH % PATTERN_WIDTH) != 0 || LVDS_WIDTH < 64 ||
        LOCK_PAIRS < 1 || LOCK_PAIRS > 15) begin : g_bad_cfg
        $error("sensor_frame_rx: illegal parameter set");
    end

    state_t      r_state;
    logic [3:0]  r_pair_cnt;
    logic [31:0] r_cnt;
    logic [31:0] r_cpf;

    logic        w_idle0, w_idle1, w_hdr;
    logic        w_sof, w_beat, w_last, w_sync_fault;
    logic [3:0]  w_pair_nxt;
    logic [31:0] w_cnt_nxt, w_cpf_in;

    assign w_idle0    = lvds == {(LVDS_WIDTH/8){idle_0}};
    assign w_idle1    = lvds == {(LVDS_WIDTH/8){idle_1}};
    assign w_hdr      = lvds[LVDS_WIDTH-1 -: HEADER_WIDTH] == frame_header;
    assign w_pair_nxt = r_pair_cnt + 4'd1;
    assign w_cnt_nxt  = r_cnt + 32'd1;
    assign w_cpf_in   = (cycles_per_frame < 32'(MIN_CPF)) ?
                        32'(MIN_CPF) : cycles_per_frame;

    // Idle_0 wins over a header match when both could apply
    assign w_sof  = (r_state == EXP_ANY) && !w_idle0 && w_hdr;
    assign w_last = (r_state == FRAME) && (w_cnt_nxt == r_cpf);
    assign w_beat = w_sof || (r_state == FRAME);
    assign w_sync_fault = ((r_state == EXP_ANY) && !w_idle0 && !w_hdr) ||
                          ((r_state == EXP_IDLE1) && !w_idle1);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state         <= HUNT0;
            r_pair_cnt      <= '0;
            r_cnt           <= '0;
            r_cpf           <= '0;
            m_axis.M_TDATA  <= '0;
            m_axis.M_TVALID <= 1'b0;
            m_axis.M_TUSER  <= 1'b0;
            m_axis.M_TLAST  <= 1'b0;
            locked          <= 1'b0;
            sync_err        <= 1'b0;
            eof_err         <= 1'b0;
            sync_err_count  <= '0;
            frame_count     <= '0;
        end else begin
            m_axis.M_TVALID <= w_beat;
            m_axis.M_TUSER  <= w_sof;
            m_axis.M_TLAST  <= w_last;
            if (w_beat) m_axis.M_TDATA <= lvds;
            eof_err  <= w_last && (lvds[31:0] != 32'd0);
            sync_err <= w_sync_fault;

            unique case (r_state)
                HUNT0: begin
                    if (w_idle0) r_state <= HUNT1;
                    else r_pair_cnt <= '0;
                end
                HUNT1: begin
                    if (w_idle1) begin
                        r_pair_cnt <= w_pair_nxt;
                        if (w_pair_nxt == 4'(LOCK_PAIRS)) begin
                            r_state <= EXP_ANY;
                            locked  <= 1'b1;
                        end else begin
                            r_state <= HUNT0;
                        end
                    end else begin
                        r_pair_cnt <= '0;
                        r_state    <= HUNT0;
                    end
                end
                EXP_ANY: begin
                    if (w_idle0) begin
                        r_state <= EXP_IDLE1;
                    end else if (w_hdr) begin
                        r_cnt   <= 32'd1;
                        r_cpf   <= w_cpf_in;
                        r_state <= FRAME;
                    end
                end
                EXP_IDLE1: begin
                    if (w_idle1) r_state <= EXP_ANY;
                end
                FRAME: begin
                    r_cnt <= w_cnt_nxt;
                    if (w_last) begin
                        frame_count <= frame_count + 32'd1;
                        r_state     <= EXP_ANY;
                    end
                end
                default: r_state <= HUNT0;
            endcase

            // A sync fault drops lock; the next word is judged in HUNT0
            if (w_sync_fault) begin
                locked     <= 1'b0;
                r_pair_cnt <= '0;
                r_state    <= HUNT0;
                if (sync_err_count != '1)
                    sync_err_count <= sync_err_count + 1'b1;
            end
        end
    end

`ifdef SENSOR_RX_DATA_CHECK_EN
    logic w_data_err;

    sensor_rx_pattern_chk #(
        .LVDS_WIDTH   (LVDS_WIDTH),
        .PATTERN_WIDTH(PATTERN_WIDTH)
    ) u_pattern_chk (
        .clk       (clk),
        .resetn    (resetn),
        .i_lvds    (lvds),
        .i_sof     (w_sof),
        .i_beat    (w_beat),
        .i_last    (w_last),
        .o_mismatch(w_data_err)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            data_err       <= 1'b0;
            data_err_count <= '0;
        end else begin
            data_err <= w_data_err;
            if (w_data_err && data_err_count != '1)
                data_err_count <= data_err_count + 1'b1;
        end
    end
`else
    assign data_err       = 1'b0;
    assign data_err_count = '0;
`endif
endmodule

// File: tb/tb_sensor_frame_rx.sv
// Directed bench for sensor_frame_rx: lock, framing, errors, reset.
// Expected data_err behaviour follows SENSOR_RX_DATA_CHECK_EN.
module tb_sensor_frame_rx;
    localparam int LW = 512;
`ifdef SENSOR_RX_DATA_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic [LW-1:0] lvds = '0;
    logic [7:0]    idle_0 = 8'hA5;
    logic [7:0]    idle_1 = 8'h5A;
    logic [31:0]   frame_header = 32'hDEADBEEF;
    logic [31:0]   cycles_per_frame = 32'd8;
    logic          locked, sync_err, eof_err, data_err;
    logic [15:0]   sync_err_count, data_err_count;
    logic [31:0]   frame_count;

    int total = 0;
    int bad = 0;
    int exp_frames = 0;

    sensor_frame_rx_if #(.LVDS_WIDTH(LW)) axis ();

    sensor_frame_rx #(
        .LVDS_WIDTH(LW), .PATTERN_WIDTH(32), .LOCK_PAIRS(4)
    ) dut (
        .clk             (clk),
        .resetn          (resetn),
        .lvds            (lvds),
        .idle_0          (idle_0),
        .idle_1          (idle_1),
        .frame_header    (frame_header),
        .cycles_per_frame(cycles_per_frame),
        .m_axis          (axis),
        .locked          (locked),
        .sync_err        (sync_err),
        .eof_err         (eof_err),
        .data_err        (data_err),
        .sync_err_count  (sync_err_count),
        .data_err_count  (data_err_count),
        .frame_count     (frame_count)
    );

    always #5 clk = ~clk;

    function automatic logic [LW-1:0] idle_w(input logic [7:0] b);
        return {64{b}};
    endfunction

    function automatic logic [LW-1:0] hdr_w(input logic [31:0] h, input logic [31:0] p);
        return {h, {15{p}}};
    endfunction

    function automatic logic [LW-1:0] mid_w(input logic [31:0] p);
        return {16{p}};
    endfunction

    function automatic logic [LW-1:0] last_w(input logic [31:0] p, input logic [31:0] lo);
        return {{15{p}}, lo};
    endfunction

    task automatic step(input logic [LW-1:0] w);
        lvds = w;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_pair();
        step(idle_w(idle_0));
        step(idle_w(idle_1));
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        step(idle_w(8'h00));
        step(idle_w(8'h00));
        total++;
        if (axis.M_TVALID !== 1'b0 || axis.M_TLAST !== 1'b0 || axis.M_TUSER !== 1'b0) begin
            bad++;
            $display("FAIL reset_axis got=%b%b%b exp=000", axis.M_TVALID, axis.M_TUSER, axis.M_TLAST);
        end
        total++;
        if (locked !== 1'b0 || sync_err !== 1'b0 || eof_err !== 1'b0 || data_err !== 1'b0) begin
            bad++;
            $display("FAIL reset_flags got=%b%b%b%b exp=0000", locked, sync_err, eof_err, data_err);
        end
        total++;
        if (frame_count !== 32'd0 || sync_err_count !== 16'd0 || data_err_count !== 16'd0) begin
            bad++;
            $display("FAIL reset_counts got=%0d/%0d/%0d exp=0/0/0", frame_count, sync_err_count, data_err_count);
        end
        resetn = 1'b1;
    endtask

    task automatic test_lock(input string tag);
        int errs;
        errs = 0;
        for (int p = 1; p <= 4; p++) begin
            step(idle_w(idle_0));
            if (sync_err !== 1'b0) errs++;
            step(idle_w(idle_1));
            if (sync_err !== 1'b0) errs++;
            if (p == 3) begin
                total++;
                if (locked !== 1'b0) begin
                    bad++;
                    $display("FAIL %s_early got=%b exp=0", tag, locked);
                end
            end
        end
        total++;
        if (locked !== 1'b1) begin
            bad++;
            $display("FAIL %s_locked got=%b exp=1", tag, locked);
        end
        total++;
        if (errs != 0) begin
            bad++;
            $display("FAIL %s_sync_strobe got=%0d exp=0", tag, errs);
        end
    endtask

    task automatic test_single_frame();
        logic [LW-1:0] w;
        logic [31:0] pat;
        pat = 32'h12345678;
        cycles_per_frame = 32'd8;
        for (int i = 1; i <= 8; i++) begin
            if (i == 1) w = hdr_w(frame_header, pat);
            else if (i == 8) w = last_w(pat, 32'd0);
            else w = mid_w(pat);
            step(w);
            total++;
            if (axis.M_TVALID !== 1'b1 || axis.M_TUSER !== (i == 1) || axis.M_TLAST !== (i == 8)) begin
                bad++;
                $display("FAIL single_ctl beat%0d got=%b%b%b", i, axis.M_TVALID, axis.M_TUSER, axis.M_TLAST);
            end
            total++;
            if (axis.M_TDATA !== w) begin
                bad++;
                $display("FAIL single_data beat%0d got=%h exp=%h", i, axis.M_TDATA, w);
            end
            total++;
            if (eof_err !== 1'b0 || data_err !== 1'b0 || sync_err !== 1'b0) begin
                bad++;
                $display("FAIL single_err beat%0d got=%b%b%b exp=000", i, eof_err, data_err, sync_err);
            end
        end
        exp_frames++;
        step(idle_w(idle_0));
        total++;
        if (axis.M_TVALID !== 1'b0) begin
            bad++;
            $display("FAIL single_gap got=%b exp=0", axis.M_TVALID);
        end
        total++;
        if (frame_count !== 32'(exp_frames)) begin
            bad++;
            $display("FAIL single_count got=%0d exp=%0d", frame_count, exp_frames);
        end
        step(idle_w(idle_1));
    endtask

    task automatic test_back_to_back();
        logic [LW-1:0] w;
        logic [31:0] pat;
        int b;
        pat = 32'hA1B2C3D4;
        cycles_per_frame = 32'd6;
        for (int j = 0; j < 12; j++) begin
            b = (j % 6) + 1;
            if (b == 1) w = hdr_w(frame_header, pat);
            else if (b == 6) w = last_w(pat, 32'd0);
            else w = mid_w(pat);
            step(w);
            total++;
            if (axis.M_TVALID !== 1'b1 || axis.M_TUSER !== (b == 1) || axis.M_TLAST !== (b == 6)) begin
                bad++;
                $display("FAIL b2b_ctl beat%0d got=%b%b%b", j + 1, axis.M_TVALID, axis.M_TUSER, axis.M_TLAST);
            end
            total++;
            if (sync_err !== 1'b0 || data_err !== 1'b0) begin
                bad++;
                $display("FAIL b2b_err beat%0d got=%b%b exp=00", j + 1, sync_err, data_err);
            end
        end
        exp_frames += 2;
        step(idle_w(idle_0));
        total++;
        if (axis.M_TVALID !== 1'b0 || frame_count !== 32'(exp_frames)) begin
            bad++;
            $display("FAIL b2b_end got=%b/%0d exp=0/%0d", axis.M_TVALID, frame_count, exp_frames);
        end
        step(idle_w(idle_1));
    endtask

    task automatic test_min_cpf();
        logic [31:0] pat;
        pat = 32'hCAFEF00D;
        cycles_per_frame = 32'd2;
        step(hdr_w(frame_header, pat));
        cycles_per_frame = 32'd9;
        for (int i = 2; i <= 4; i++) begin
            step(i == 4 ? last_w(pat, 32'd0) : mid_w(pat));
            total++;
            if (axis.M_TVALID !== 1'b1 || axis.M_TLAST !== (i == 4)) begin
                bad++;
                $display("FAIL mincpf_ctl beat%0d got=%b%b", i, axis.M_TVALID, axis.M_TLAST);
            end
        end
        exp_frames++;
        step(idle_w(idle_0));
        total++;
        if (axis.M_TVALID !== 1'b0 || frame_count !== 32'(exp_frames)) begin
            bad++;
            $display("FAIL mincpf_end got=%b/%0d exp=0/%0d", axis.M_TVALID, frame_count, exp_frames);
        end
        step(idle_w(idle_1));
    endtask

    task automatic test_sync_err();
        step(idle_w(idle_0));
        total++;
        if (sync_err !== 1'b0 || locked !== 1'b1) begin
            bad++;
            $display("FAIL sync_first got=%b%b exp=01", sync_err, locked);
        end
        step(idle_w(idle_0));
        total++;
        if (sync_err !== 1'b1 || locked !== 1'b0) begin
            bad++;
            $display("FAIL sync_pulse got=%b%b exp=10", sync_err, locked);
        end
        total++;
        if (sync_err_count !== 16'd1) begin
            bad++;
            $display("FAIL sync_count got=%0d exp=1", sync_err_count);
        end
        test_lock("relock");
    endtask

    task automatic test_eof_data();
        logic [LW-1:0] w;
        logic [31:0] pat;
        pat = 32'h0F1E2D3C;
        cycles_per_frame = 32'd6;
        for (int i = 1; i <= 6; i++) begin
            if (i == 1) w = hdr_w(frame_header, pat);
            else if (i == 6) w = last_w(pat, 32'd1);
            else w = mid_w(pat);
            if (i == 4) w[127:96] = w[127:96] ^ 32'h00FF0000;
            step(w);
            total++;
            if (eof_err !== (i == 6) || axis.M_TLAST !== (i == 6)) begin
                bad++;
                $display("FAIL eof beat%0d got=%b%b", i, eof_err, axis.M_TLAST);
            end
            total++;
            if (data_err !== (CHK && i == 4)) begin
                bad++;
                $display("FAIL data_err beat%0d got=%b exp=%b", i, data_err, CHK && i == 4);
            end
        end
        exp_frames++;
        total++;
        if (data_err_count !== (CHK ? 16'd1 : 16'd0)) begin
            bad++;
            $display("FAIL data_count got=%0d exp=%0d", data_err_count, CHK ? 1 : 0);
        end
        step(idle_w(idle_0));
        total++;
        if (frame_count !== 32'(exp_frames) || eof_err !== 1'b0) begin
            bad++;
            $display("FAIL eof_end got=%0d/%b exp=%0d/0", frame_count, eof_err, exp_frames);
        end
        step(idle_w(idle_1));
    endtask

    task automatic test_reset_mid();
        logic [31:0] pat;
        int seen;
        pat = 32'h55AA33CC;
        cycles_per_frame = 32'd8;
        step(hdr_w(frame_header, pat));
        step(mid_w(pat));
        resetn = 1'b0;
        step(mid_w(pat));
        total++;
        if (axis.M_TVALID !== 1'b0 || axis.M_TLAST !== 1'b0 || locked !== 1'b0) begin
            bad++;
            $display("FAIL rstmid_ctl got=%b%b%b exp=000", axis.M_TVALID, axis.M_TLAST, locked);
        end
        total++;
        if (frame_count !== 32'd0 || sync_err_count !== 16'd0 || data_err_count !== 16'd0) begin
            bad++;
            $display("FAIL rstmid_counts got=%0d/%0d/%0d exp=0/0/0", frame_count, sync_err_count, data_err_count);
        end
        resetn = 1'b1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            step(i == 7 ? last_w(pat, 32'd0) : mid_w(pat));
            if (axis.M_TVALID !== 1'b0 || axis.M_TLAST !== 1'b0) seen++;
        end
        total++;
        if (seen != 0) begin
            bad++;
            $display("FAIL rstmid_tail got=%0d exp=0", seen);
        end
    endtask

    initial begin
        test_reset();
        test_lock("lock");
        test_single_frame();
        test_back_to_back();
        test_min_cpf();
        test_sync_err();
        test_eof_data();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
